// File: rtl/mac_pkg.sv
// Shared MAC definitions: CRC-32 constants, receive FSM
// encoding and status-word layout used by the RX and TX paths.
package mac_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    localparam int STAT_FCS_OK  = 31;
    localparam int STAT_RUNT    = 30;
    localparam int STAT_OVF     = 29;
    localparam int STAT_DRIBBLE = 28;
    localparam int STAT_LEN_HI  = 11;
    localparam int STAT_LEN_LO  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_COMMIT,
        ST_HOLD,
        ST_DISCARD
    } rx_state_t;

    function automatic logic [31:0] status_word(
        input logic        fcs_ok,
        input logic        runt,
        input logic        ovf,
        input logic        dribble,
        input logic [11:0] len
    );
        logic [31:0] w;
        w = '0;
        w[STAT_FCS_OK]  = fcs_ok;
        w[STAT_RUNT]    = runt;
        w[STAT_OVF]     = ovf;
        w[STAT_DRIBBLE] = dribble;
        w[STAT_LEN_HI:STAT_LEN_LO] = len;
        return w;
    endfunction

endpackage

// File: rtl/crc32_serial.sv
// One-bit serial CRC-32 step (non-reflected, MSB feedback),
// shared by the RX deframer and the TX framer.
module crc32_serial (
    input  logic [31:0] crc,
    input  logic        din,
    output logic [31:0] crc_next
);
    import mac_pkg::*;

    logic fb;

    // Shift left and fold the polynomial in when feedback is set
    always_comb begin
        fb       = crc[31] ^ din;
        crc_next = {crc[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
    end

endmodule

// File: rtl/mac_rx_deframer.sv
// 10BASE-T receive deframer: strips preamble/SFD, packs bits
// into buffer words from word 1, writes status at word 0.
module mac_rx_deframer #(
    parameter int ADDR_W    = 9,
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1518
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_carrier,
    input  logic              rx_bit_valid,
    input  logic              rx_bit,
    input  logic              rx_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              rxfull,
    output logic              rx_busy
);
    import mac_pkg::*;

    // Last buffer word that may hold bytes of a legal frame
    localparam logic [9:0]  LAST_W  = 10'((MAX_BYTES + 3) / 4);
    localparam logic [11:0] MAX_LEN = 12'(MAX_BYTES);
    localparam logic [11:0] MIN_LEN = 12'(MIN_BYTES);

    rx_state_t         state;
    rx_state_t         state_nx;
    logic              phase;
    logic              prev;
    logic [14:0]       cnt;
    logic [14:0]       cnt_inc;
    logic [31:0]       crc;
    logic [31:0]       crc_byte;
    logic [31:0]       crc_nx;
    logic [31:0]       sreg;
    logic [31:0]       word_q;
    logic              word_wr_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic              ovf;
    logic              full_q;
    logic              take;
    logic [9:0]        part_word;
    logic              part_ok;
    logic [11:0]       len;

    crc32_serial u_crc (
        .crc      (crc),
        .din      (rx_bit),
        .crc_next (crc_nx)
    );

    // Bit intake, counters and commit-side derived values
    always_comb begin
        take      = (state == ST_DATA) && rx_bit_valid;
        cnt_inc   = (cnt == 15'h7fff) ? cnt : cnt + 15'd1;
        part_word = cnt[14:5] + 10'd1;
        part_ok   = (cnt[4:0] != 5'd0) && (part_word <= LAST_W);
        len       = cnt[14:3];
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; ack in HOLD wins over a new carrier
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (rx_carrier)
                    state_nx = full_q ? ST_DISCARD : ST_PREAMBLE;
                else if (full_q)
                    state_nx = ST_HOLD;
            end
            ST_PREAMBLE: begin
                if (!rx_carrier)
                    state_nx = ST_IDLE;
                else if (rx_bit_valid && rx_bit && prev)
                    state_nx = ST_DATA;
            end
            ST_DATA:    if (!rx_carrier) state_nx = ST_COMMIT;
            ST_COMMIT:  if (phase) state_nx = ST_HOLD;
            ST_HOLD: begin
                if (rx_ack)          state_nx = ST_IDLE;
                else if (rx_carrier) state_nx = ST_DISCARD;
            end
            ST_DISCARD: if (!rx_carrier) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Datapath: packing, CRC, counters, flags
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            phase       <= 1'b0;
            prev        <= 1'b0;
            cnt         <= '0;
            crc         <= CRC32_INIT;
            crc_byte    <= CRC32_INIT;
            sreg        <= '0;
            word_q      <= '0;
            word_wr_q   <= 1'b0;
            word_addr_q <= '0;
            ovf         <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            word_wr_q <= 1'b0;
            phase     <= (state == ST_COMMIT) && !phase;
            if (state == ST_IDLE)
                prev <= 1'b0;
            else if (state == ST_PREAMBLE && rx_bit_valid)
                prev <= rx_bit;
            if (take) begin
                crc <= crc_nx;
                cnt <= cnt_inc;
                if (cnt_inc[2:0] == 3'd0)
                    crc_byte <= crc_nx;
                if (cnt_inc[14:3] > MAX_LEN)
                    ovf <= 1'b1;
                if (cnt_inc[4:0] == 5'd0) begin
                    word_q      <= {rx_bit, sreg[30:0]};
                    sreg        <= '0;
                    word_addr_q <= ADDR_W'(cnt_inc[14:5]);
                    word_wr_q   <= (cnt_inc[14:5] <= LAST_W);
                end else begin
                    sreg[cnt[4:0]] <= rx_bit;
                end
            end
            if (state == ST_COMMIT && phase)
                full_q <= 1'b1;
            if (state == ST_HOLD && rx_ack) begin
                full_q   <= 1'b0;
                cnt      <= '0;
                crc      <= CRC32_INIT;
                crc_byte <= CRC32_INIT;
                sreg     <= '0;
                ovf      <= 1'b0;
            end
        end
    end

    // Outputs: data-word pulses, partial word, then status word
    always_comb begin
        wr_en   = word_wr_q;
        wr_addr = word_addr_q;
        wr_data = word_q;
        rxfull  = full_q;
        rx_busy = (state == ST_DATA) || (state == ST_COMMIT);
        if (state == ST_COMMIT) begin
            if (phase) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = status_word(crc_byte == CRC32_RESIDUE,
                                      len < MIN_LEN, ovf,
                                      cnt[2:0] != 3'd0, len);
            end else if (part_ok) begin
                wr_en   = 1'b1;
                wr_addr = ADDR_W'(part_word);
                wr_data = sreg;
            end
        end
    end

endmodule
